// File: rtl/door_pkg.sv
// Shared definitions for the switch-code door lock controller.
// Holds the displayed state encoding, the power-on code and the width of the
// tick counters used for every timed interval.
package door_pkg;

   // State encoding is visible on the board display, so values are fixed.
   typedef enum logic [3:0] {
      S_IDLE         = 4'd0,
      S_CHECK        = 4'd1,
      S_OPEN         = 4'd2,
      S_WRONG        = 4'd3,
      S_LOCKED       = 4'd4,
      S_PROG_AUTH    = 4'd5,
      S_PROG_NEW     = 4'd6,
      S_PROG_CONFIRM = 4'd7,
      S_PROG_DONE    = 4'd8
   } doorState_e;

   localparam logic [7:0] DOOR_DEFAULT_CODE = 8'hA5;

   // Wide enough for the longest interval (lockout / programming timeout).
   localparam int TICK_W = 8;
   typedef logic [TICK_W-1:0] tickCount_t;

   // The attempt counter is two bits and must never wrap back to zero.
   function automatic logic [1:0] satInc(input logic [1:0] value);
      return (value == 2'd3) ? value : value + 2'd1;
   endfunction

endpackage

// File: rtl/tick_timer.sv
// Tick-enable interval counter.
// Counts tick pulses while enabled and flags the cycle in which the
// limit-th tick arrives, so the owner can move on at the next clock edge.
// Ports:
//   clk_i    - system clock
//   rst_ni   - asynchronous active-low reset
//   clear_i  - synchronous clear (owner asserts it on every state change)
//   enable_i - count only while the owner is in a timed state
//   tick_i   - one-cycle timebase enable
//   limit_i  - number of ticks that make up the interval (>= 1)
//   done_o   - high in the cycle the limit-th tick is seen
module tick_timer
   import door_pkg::*;
(
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       clear_i,
   input  logic       enable_i,
   input  logic       tick_i,
   input  tickCount_t limit_i,
   output logic       done_o
);

   tickCount_t count_q;

   // Saturating tick counter; clear has priority over counting so a fresh
   // interval always starts from zero.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         count_q <= '0;
      end else if (clear_i) begin
         count_q <= '0;
      end else if (enable_i && tick_i && (count_q != '1)) begin
         count_q <= count_q + tickCount_t'(1);
      end
   end

   // The tick being seen now is the (count_q+1)-th one.
   assign done_o = enable_i && tick_i && (count_q == (limit_i - tickCount_t'(1)));

endmodule

// File: rtl/door_access_ctrl.sv
// Sequencing controller for the switch-code door lock.
// Runs code entry and check, timed unlock, failed-attempt counting with a
// timed lockout, and a three-step reprogram sequence for the stored code.
// Ports:
//   clock_in  - system clock
//   clr       - asynchronous active-low reset
//   tick      - one-cycle timebase enable from the divider
//   enter     - one-cycle pulse, submit sw
//   prog      - one-cycle pulse, start or abort reprogramming
//   sw        - code switches, sampled only on enter
//   unlock    - door release
//   LED_right - success indicator
//   LED_wrong - failure / lockout indicator
//   lockout   - high while locked out
//   counter   - current failed-attempt count
//   state     - current state encoding for display
module door_access_ctrl
   import door_pkg::*;
#(
   parameter logic [7:0] DEFAULT_CODE = DOOR_DEFAULT_CODE,
   parameter int         MAX_TRIES    = 3,
   parameter int         OPEN_TICKS   = 5,
   parameter int         WRONG_TICKS  = 2,
   parameter int         LOCK_TICKS   = 10,
   parameter int         PROG_TIMEOUT = 15
)
(
   input  logic       clock_in,
   input  logic       clr,
   input  logic       tick,
   input  logic       enter,
   input  logic       prog,
   input  logic [7:0] sw,
   output logic       unlock,
   output logic       LED_right,
   output logic       LED_wrong,
   output logic       lockout,
   output logic [1:0] counter,
   output logic [3:0] state
);

   doorState_e state_q, state_d;
   logic [7:0] code_q, code_d;
   logic [7:0] entry_q, entry_d;
   logic [7:0] pending_q, pending_d;
   logic [1:0] attempts_q, attempts_d;
   logic       unlock_q, ledRight_q, ledWrong_q, lockout_q;

   logic       timerEnable, timerClear, timerDone;
   tickCount_t timerLimit;
   logic [2:0] attemptsPlusOne;
   logic       failLocks;

   // Interval length depends only on the current state, which keeps the
   // timer's done output free of any path back through the next-state logic.
   always_comb begin
      timerEnable = 1'b1;
      timerLimit  = tickCount_t'(PROG_TIMEOUT);
      case (state_q)
         S_OPEN:                                  timerLimit = tickCount_t'(OPEN_TICKS);
         S_WRONG, S_PROG_DONE:                    timerLimit = tickCount_t'(WRONG_TICKS);
         S_LOCKED:                                timerLimit = tickCount_t'(LOCK_TICKS);
         S_PROG_AUTH, S_PROG_NEW, S_PROG_CONFIRM: timerLimit = tickCount_t'(PROG_TIMEOUT);
         default:                                 timerEnable = 1'b0;
      endcase
   end

   // Every enter in a programming state moves to another state, so clearing
   // on state change also restarts the idle timeout on each enter.
   assign timerClear = (state_d != state_q);

   tick_timer u_timer (
      .clk_i   (clock_in),
      .rst_ni  (clr),
      .clear_i (timerClear),
      .enable_i(timerEnable),
      .tick_i  (tick),
      .limit_i (timerLimit),
      .done_o  (timerDone)
   );

   // A failed check either locks out (when this failure reaches the limit)
   // or bumps the saturating attempt count.
   assign attemptsPlusOne = {1'b0, attempts_q} + 3'd1;
   assign failLocks       = (attemptsPlusOne == 3'(MAX_TRIES));

   // Next-state and datapath updates. Enter always beats prog and beats a
   // coincident timeout tick; timed display states ignore the buttons.
   always_comb begin
      state_d    = state_q;
      code_d     = code_q;
      entry_d    = entry_q;
      pending_d  = pending_q;
      attempts_d = attempts_q;
      case (state_q)
         S_IDLE: begin
            if (enter) begin
               entry_d = sw;
               state_d = S_CHECK;
            end else if (prog) begin
               state_d = S_PROG_AUTH;
            end
         end
         S_CHECK: begin
            if (entry_q == code_q) begin
               attempts_d = 2'd0;
               state_d    = S_OPEN;
            end else if (failLocks) begin
               attempts_d = 2'(MAX_TRIES);
               state_d    = S_LOCKED;
            end else begin
               attempts_d = satInc(attempts_q);
               state_d    = S_WRONG;
            end
         end
         S_OPEN, S_WRONG, S_PROG_DONE: begin
            if (timerDone) state_d = S_IDLE;
         end
         S_LOCKED: begin
            if (timerDone) begin
               attempts_d = 2'd0;
               state_d    = S_IDLE;
            end
         end
         S_PROG_AUTH: begin
            if (enter) begin
               if (sw == code_q) begin
                  state_d = S_PROG_NEW;
               end else if (failLocks) begin
                  attempts_d = 2'(MAX_TRIES);
                  state_d    = S_LOCKED;
               end else begin
                  attempts_d = satInc(attempts_q);
                  state_d    = S_WRONG;
               end
            end else if (prog || timerDone) begin
               state_d = S_IDLE;
            end
         end
         S_PROG_NEW: begin
            if (enter) begin
               pending_d = sw;
               state_d   = S_PROG_CONFIRM;
            end else if (prog || timerDone) begin
               state_d = S_IDLE;
            end
         end
         S_PROG_CONFIRM: begin
            if (enter) begin
               if (sw == pending_q) begin
                  code_d  = pending_q;
                  state_d = S_PROG_DONE;
               end else begin
                  state_d = S_WRONG;
               end
            end else if (prog || timerDone) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State, datapath and output registers. Outputs are decoded from the
   // next state so they line up exactly with the registered state.
   always_ff @(posedge clock_in or negedge clr) begin
      if (!clr) begin
         state_q    <= S_IDLE;
         code_q     <= DEFAULT_CODE;
         entry_q    <= 8'd0;
         pending_q  <= 8'd0;
         attempts_q <= 2'd0;
         unlock_q   <= 1'b0;
         ledRight_q <= 1'b0;
         ledWrong_q <= 1'b0;
         lockout_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         code_q     <= code_d;
         entry_q    <= entry_d;
         pending_q  <= pending_d;
         attempts_q <= attempts_d;
         unlock_q   <= (state_d == S_OPEN);
         ledRight_q <= (state_d == S_OPEN) || (state_d == S_PROG_DONE);
         ledWrong_q <= (state_d == S_WRONG) || (state_d == S_LOCKED);
         lockout_q  <= (state_d == S_LOCKED);
      end
   end

   assign unlock    = unlock_q;
   assign LED_right = ledRight_q;
   assign LED_wrong = ledWrong_q;
   assign lockout   = lockout_q;
   assign counter   = attempts_q;
   assign state     = state_q;

endmodule

// File: tb/tb_door_access_ctrl.sv
// Self-checking bench for door_access_ctrl.
// A transaction-level model (stored code, failed-attempt count) predicts the
// outcome of each code entry or reprogram sequence; the bench then measures
// how many ticks each indicator stays high and compares with the interval
// lengths of the lock protocol.
module tb_door_access_ctrl;

   localparam int MAX_TRIES    = 3;
   localparam int OPEN_TICKS   = 5;
   localparam int WRONG_TICKS  = 2;
   localparam int LOCK_TICKS   = 10;
   localparam int PROG_TIMEOUT = 15;

   logic       clock_in = 1'b0;
   logic       clr      = 1'b0;
   logic       tick     = 1'b0;
   logic       enter    = 1'b0;
   logic       prog     = 1'b0;
   logic [7:0] sw       = 8'd0;
   logic       unlock, LED_right, LED_wrong, lockout;
   logic [1:0] counter;
   logic [3:0] state;

   int passCount  = 0;
   int checkCount = 0;
   int cycleCount = 0;
   int tickPeriod = 3;
   int mCode      = 8'hA5;
   int mAttempts  = 0;

   door_access_ctrl #(
      .DEFAULT_CODE(8'hA5),
      .MAX_TRIES   (MAX_TRIES),
      .OPEN_TICKS  (OPEN_TICKS),
      .WRONG_TICKS (WRONG_TICKS),
      .LOCK_TICKS  (LOCK_TICKS),
      .PROG_TIMEOUT(PROG_TIMEOUT)
   ) dut (
      .clock_in (clock_in),
      .clr      (clr),
      .tick     (tick),
      .enter    (enter),
      .prog     (prog),
      .sw       (sw),
      .unlock   (unlock),
      .LED_right(LED_right),
      .LED_wrong(LED_wrong),
      .lockout  (lockout),
      .counter  (counter),
      .state    (state)
   );

   always #5 clock_in = ~clock_in;

   // Advance one clock; pulses last exactly one cycle and the divider tick
   // is regenerated for the coming cycle.
   task automatic stepCycle();
      @(posedge clock_in);
      #1;
      enter = 1'b0;
      prog  = 1'b0;
      cycleCount++;
      tick = ((cycleCount % tickPeriod) == 0);
   endtask

   function automatic logic selSig(input int which);
      case (which)
         0:       return unlock;
         1:       return LED_wrong;
         2:       return lockout;
         3:       return LED_right;
         default: return (state == 4'(which - 10));
      endcase
   endfunction

   // Count ticks seen while the selected signal stays high, optionally
   // spraying button pulses that must all be ignored.
   task automatic measureTicks(input int which, input bit inject, output int ticks);
      int cycles;
      ticks  = 0;
      cycles = 0;
      while (selSig(which) && cycles < 1000) begin
         if (tick) ticks++;
         if (inject && $urandom_range(0, 2) == 0) begin
            sw = 8'($urandom);
            if ($urandom_range(0, 1) == 1) enter = 1'b1;
            else prog = 1'b1;
         end
         stepCycle();
         cycles++;
      end
      if (cycles >= 1000) begin
         checkCount++;
         $display("[TB] FAIL measure_bound: signal %0d still high after %0d cycles, required to drop", which, cycles);
      end
   endtask

   // Model of a failed check: either the limit is reached (locked) or the
   // count goes up by one. Returns the display code of the resulting state.
   function automatic int modelFail();
      if (mAttempts + 1 >= MAX_TRIES) begin
         mAttempts = MAX_TRIES;
         return 4;
      end
      mAttempts++;
      return 3;
   endfunction

   function automatic logic [7:0] wrongCode();
      logic [7:0] v;
      v = 8'($urandom);
      if (v == 8'(mCode)) v = v ^ 8'h01;
      return v;
   endfunction

   // Follows a timed outcome state from its first cycle back to idle.
   task automatic finishOutcome(input int expState);
      int         which, expTicks, ticks;
      logic [3:0] expLeds;
      case (expState)
         2:       begin which = 0; expTicks = OPEN_TICKS;  expLeds = 4'b1100; end
         3:       begin which = 1; expTicks = WRONG_TICKS; expLeds = 4'b0010; end
         4:       begin which = 2; expTicks = LOCK_TICKS;  expLeds = 4'b0011; end
         default: begin which = 3; expTicks = WRONG_TICKS; expLeds = 4'b0100; end
      endcase
      checkCount++;
      if (state !== 4'(expState)) $display("[TB] FAIL outcome_state: got %0d expected %0d", state, expState);
      else passCount++;
      checkCount++;
      if (counter !== 2'(mAttempts)) $display("[TB] FAIL outcome_counter: got %0d expected %0d", counter, mAttempts);
      else passCount++;
      checkCount++;
      if ({unlock, LED_right, LED_wrong, lockout} !== expLeds)
         $display("[TB] FAIL outcome_leds: got %b expected %b", {unlock, LED_right, LED_wrong, lockout}, expLeds);
      else passCount++;
      measureTicks(which, 1'b1, ticks);
      checkCount++;
      if (ticks !== expTicks) $display("[TB] FAIL outcome_ticks: state %0d lasted %0d ticks expected %0d", expState, ticks, expTicks);
      else passCount++;
      if (expState == 4) mAttempts = 0;
      checkCount++;
      if (state !== 4'd0 || {unlock, LED_right, LED_wrong, lockout} !== 4'b0000)
         $display("[TB] FAIL return_idle: got state %0d leds %b expected state 0 leds 0000", state, {unlock, LED_right, LED_wrong, lockout});
      else passCount++;
      checkCount++;
      if (counter !== 2'(mAttempts)) $display("[TB] FAIL idle_counter: got %0d expected %0d", counter, mAttempts);
      else passCount++;
   endtask

   task automatic doAttempt(input logic [7:0] value);
      int expState;
      sw    = value;
      enter = 1'b1;
      prog  = ($urandom_range(0, 1) == 1);
      stepCycle();
      checkCount++;
      if (state !== 4'd1) $display("[TB] FAIL check_cycle: got state %0d expected 1", state);
      else passCount++;
      if (int'(value) == mCode) begin
         mAttempts = 0;
         expState  = 2;
      end else begin
         expState = modelFail();
      end
      stepCycle();
      finishOutcome(expState);
   endtask

   task automatic doReprogram(input logic [7:0] auth, input logic [7:0] newCode, input logic [7:0] confirm);
      int expState;
      prog = 1'b1;
      stepCycle();
      checkCount++;
      if (state !== 4'd5) $display("[TB] FAIL prog_auth_entry: got state %0d expected 5", state);
      else passCount++;
      repeat ($urandom_range(0, 4)) stepCycle();
      sw    = auth;
      enter = 1'b1;
      stepCycle();
      if (int'(auth) != mCode) begin
         finishOutcome(modelFail());
         return;
      end
      checkCount++;
      if (state !== 4'd6) $display("[TB] FAIL prog_new_entry: got state %0d expected 6", state);
      else passCount++;
      repeat ($urandom_range(0, 4)) stepCycle();
      sw    = newCode;
      enter = 1'b1;
      stepCycle();
      checkCount++;
      if (state !== 4'd7) $display("[TB] FAIL prog_confirm_entry: got state %0d expected 7", state);
      else passCount++;
      repeat ($urandom_range(0, 4)) stepCycle();
      sw    = confirm;
      enter = 1'b1;
      stepCycle();
      if (confirm == newCode) begin
         mCode    = int'(newCode);
         expState = 8;
      end else begin
         expState = 3;
      end
      finishOutcome(expState);
   endtask

   task automatic test_reset();
      clr = 1'b0;
      repeat (3) stepCycle();
      checkCount++;
      if (state !== 4'd0 || counter !== 2'd0) $display("[TB] FAIL reset_state: got state %0d counter %0d expected 0 0", state, counter);
      else passCount++;
      checkCount++;
      if ({unlock, LED_right, LED_wrong, lockout} !== 4'b0000)
         $display("[TB] FAIL reset_outputs: got %b expected 0000", {unlock, LED_right, LED_wrong, lockout});
      else passCount++;
      clr = 1'b1;
      stepCycle();
   endtask

   task automatic test_correct_code();
      tickPeriod = 3;
      doAttempt(8'hA5);
   endtask

   task automatic test_wrong_lockout();
      tickPeriod = 2;
      doAttempt(8'h00);
      doAttempt(8'h00);
      doAttempt(wrongCode());
   endtask

   task automatic test_recovery();
      tickPeriod = $urandom_range(1, 4);
      doAttempt(wrongCode());
      doAttempt(wrongCode());
      doAttempt(8'(mCode));
      doAttempt(wrongCode());
      checkCount++;
      if (counter !== 2'd1) $display("[TB] FAIL recovery_counter: got %0d expected 1", counter);
      else passCount++;
   endtask

   task automatic test_bad_confirm();
      tickPeriod = $urandom_range(1, 4);
      doReprogram(8'hA5, 8'h3C, 8'h3D);
      doAttempt(8'hA5);
   endtask

   task automatic test_reprogram();
      tickPeriod = $urandom_range(1, 4);
      doReprogram(8'hA5, 8'h3C, 8'h3C);
      doAttempt(8'hA5);
      doAttempt(8'h3C);
   endtask

   task automatic test_prog_timeout();
      int ticks, t, k;
      tickPeriod = $urandom_range(1, 3);
      prog = 1'b1;
      stepCycle();
      measureTicks(15, 1'b0, ticks);
      checkCount++;
      if (ticks !== PROG_TIMEOUT || state !== 4'd0)
         $display("[TB] FAIL auth_timeout: got %0d ticks state %0d expected %0d ticks state 0", ticks, state, PROG_TIMEOUT);
      else passCount++;
      prog = 1'b1;
      stepCycle();
      k = $urandom_range(5, PROG_TIMEOUT - 2);
      t = 0;
      while (t < k) begin
         if (tick) t++;
         stepCycle();
      end
      sw    = 8'(mCode);
      enter = 1'b1;
      stepCycle();
      measureTicks(16, 1'b0, ticks);
      checkCount++;
      if (ticks !== PROG_TIMEOUT || state !== 4'd0)
         $display("[TB] FAIL new_timeout: got %0d ticks state %0d expected %0d ticks state 0", ticks, state, PROG_TIMEOUT);
      else passCount++;
      doAttempt(8'(mCode));
   endtask

   task automatic test_abort();
      tickPeriod = 3;
      prog = 1'b1;
      stepCycle();
      prog = 1'b1;
      stepCycle();
      checkCount++;
      if (state !== 4'd0) $display("[TB] FAIL abort_auth: got state %0d expected 0", state);
      else passCount++;
      prog = 1'b1;
      stepCycle();
      sw    = 8'(mCode);
      enter = 1'b1;
      stepCycle();
      prog = 1'b1;
      stepCycle();
      checkCount++;
      if (state !== 4'd0 || counter !== 2'(mAttempts))
         $display("[TB] FAIL abort_new: got state %0d counter %0d expected 0 %0d", state, counter, mAttempts);
      else passCount++;
   endtask

   task automatic test_random();
      int op;
      for (int i = 0; i < 30; i++) begin
         tickPeriod = $urandom_range(1, 4);
         op = $urandom_range(0, 99);
         if (op < 60) begin
            doAttempt(($urandom_range(0, 9) < 4) ? 8'(mCode) : wrongCode());
         end else if (op < 85) begin
            logic [7:0] nc;
            nc = 8'($urandom);
            doReprogram(($urandom_range(0, 4) != 0) ? 8'(mCode) : wrongCode(), nc,
                        ($urandom_range(0, 3) != 0) ? nc : nc ^ 8'h80);
         end else begin
            prog = 1'b1;
            stepCycle();
            prog = 1'b1;
            stepCycle();
            checkCount++;
            if (state !== 4'd0) $display("[TB] FAIL random_abort: got state %0d expected 0", state);
            else passCount++;
         end
      end
   endtask

   task automatic test_reset_mid_open();
      tickPeriod = 4;
      sw    = 8'(mCode);
      enter = 1'b1;
      stepCycle();
      stepCycle();
      stepCycle();
      checkCount++;
      if (unlock !== 1'b1) $display("[TB] FAIL open_before_reset: got unlock %0d expected 1", unlock);
      else passCount++;
      #2;
      clr = 1'b0;
      #1;
      checkCount++;
      if (unlock !== 1'b0 || state !== 4'd0 || LED_right !== 1'b0)
         $display("[TB] FAIL async_reset: got unlock %0d state %0d expected 0 0", unlock, state);
      else passCount++;
      stepCycle();
      clr       = 1'b1;
      mCode     = 8'hA5;
      mAttempts = 0;
      stepCycle();
      doAttempt(8'hA5);
   endtask

   initial begin
      test_reset();
      test_correct_code();
      test_wrong_lockout();
      test_recovery();
      test_bad_confirm();
      test_reprogram();
      test_prog_timeout();
      test_abort();
      test_random();
      test_reset_mid_open();
      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
